ens_vote_argmax: RTL and testbench
==================================

Name: ens_vote_argmax

Overview:
- Downstream consumer of the final-layer LUT neurons.
- Accepts one beat per ensemble member; each beat carries that member's packed per-class scores.
- Sums the scores per class across the ensemble, then runs a sequential argmax over the sums.
- Presents the winning class index and its score on a valid/ready output for the top-level classifier wrapper.

Parameters:
- NUM_CLASSES, 10, number of output classes.
- SCORE_W, 2, bits per class score in one ensemble member's beat.
- ENS_N, 4, number of ensemble members per frame.
- IDX_W, 4, class index width; must satisfy 2^IDX_W >= NUM_CLASSES.
- ACC_W, derived localparam SCORE_W+$clog2(ENS_N)+1, accumulator width; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept a beat.
- s_data  in  NUM_CLASSES*SCORE_W  class c score in bits [c*SCORE_W +: SCORE_W], unsigned.
- s_last  in  1  final beat of the frame.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts result.
- m_class  out  IDX_W  winning class index.
- m_score  out  ACC_W  summed score of the winning class.
- m_err  out  1  frame length mismatch flag, qualified by m_valid.

Behaviour:
- Reset (async assert, sync deassert via clk): state=ACCUM; accumulators, beat counter, m_class, m_score and m_err = 0; m_valid = 0.
- s_ready = (state==ACCUM), combinational from state. s_ready is therefore 1 immediately after reset.
- State ACCUM:
  - On s_valid&&s_ready at an edge, acc[c] += s_data field c for all c (unsigned, zero-extended, no overflow possible at ACC_W).
  - Beat counter increments on each accepted beat.
  - Cycles with s_valid low are bubbles and have no effect.
- End of frame: the accepted beat with s_last=1, or the ENS_N-th accepted beat, whichever occurs first.
  - Next state is SCAN.
  - m_err is latched 1 if s_last and the ENS_N-th beat do not coincide (short frame, or missing s_last); otherwise 0.
  - After the ENS_N-th beat, any later s_last belongs to the next frame. It is not checked further.
- State SCAN:
  - One class per cycle, index i=0..NUM_CLASSES-1.
  - i=0 loads best=acc[0], best_idx=0.
  - i>0 replaces best only if acc[i] > best (strict), so ties resolve to the lowest index.
  - After i=NUM_CLASSES-1 the next state is OUT.
- Latency: m_valid rises exactly NUM_CLASSES rising edges after the edge that accepted the final beat.
- State OUT:
  - m_valid=1; m_class, m_score and m_err are held stable until m_ready.
  - s_ready=0, so input is stalled.
  - On m_valid&&m_ready: m_valid drops next cycle, all accumulators and the counter clear, state returns to ACCUM.
  - The earliest next-frame beat is accepted the edge after the output handshake.
- No combinational path from m_ready to s_ready or to any output.
- Reset mid-operation (any state): the frame is discarded and all of the reset values above apply immediately. No stale result appears afterwards.
- Accumulator clear on the output handshake and the first accumulate of a new frame never occur on the same edge.

Test Plan (NUM_CLASSES=10, SCORE_W=2, ENS_N=4):
- Nominal frame: 4 back-to-back beats, each class7=3 and others=0, s_last on beat 4 -> m_class=7, m_score=12, m_err=0; m_valid high exactly 10 edges after beat 4 is accepted.
- Tie: totals class2=6 and class5=6, all others <=5 -> m_class=2, m_score=6.
- Backpressure: hold m_ready=0 for 5 cycles after m_valid while driving s_valid=1.
  - Outputs stay stable, s_ready=0, input is ignored.
  - After the handshake, a second frame of all-class0=1 (4 beats) -> m_class=0, m_score=4, with no carryover from the first frame.
- Short frame: s_last on beat 2, with class3=2 on both beats -> m_err=1, m_class=3, m_score=4.
- Bubbles: the nominal frame with 3 idle cycles between each beat -> same result as the nominal frame, with m_valid 10 edges after the last accept.
- Reset in SCAN: assert rst_n=0 mid-scan -> m_valid=0 and s_ready=1 immediately; the next nominal frame yields m_class=7, m_score=12.

Source files
------------

// File: rtl/ens_vote_argmax_if.sv
// Score-beat input stream and winning-class result stream for the ensemble vote block.
// The slave modport is the voter's view; the master modport drives beats and consumes results.
interface ens_vote_argmax_if #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned SCORE_W     = 2,
  parameter int unsigned ENS_N       = 4,
  parameter int unsigned IDX_W       = 4
);
  localparam int unsigned ACC_W  = SCORE_W + $clog2(ENS_N) + 1;
  localparam int unsigned DATA_W = NUM_CLASSES * SCORE_W;

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              m_valid;
  logic              m_ready;
  logic [IDX_W-1:0]  m_class;
  logic [ACC_W-1:0]  m_score;
  logic              m_err;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_class, m_score, m_err
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_class, m_score, m_err
  );
endinterface

// File: rtl/ens_vote_argmax.sv
// Sums per-class scores over one frame of ensemble beats, then scans the sums one class
// per cycle for the highest total (lowest index wins ties) and holds the result until taken.
module ens_vote_argmax #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned SCORE_W     = 2,
  parameter int unsigned ENS_N       = 4,
  parameter int unsigned IDX_W       = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  ens_vote_argmax_if.slave bus
);
  localparam int unsigned ACC_W = SCORE_W + $clog2(ENS_N) + 1;
  localparam int unsigned CNT_W = $clog2(ENS_N + 1);

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q [NUM_CLASSES];
  logic [ACC_W-1:0] acc_d [NUM_CLASSES];
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] scan_idx_q;
  logic [ACC_W-1:0] best_q;
  logic [IDX_W-1:0] best_idx_q;
  logic             m_valid_q;
  logic [IDX_W-1:0] m_class_q;
  logic [ACC_W-1:0] m_score_q;
  logic             m_err_q;

  logic             accept_c;
  logic             nth_beat_c;
  logic             eof_c;
  logic             scan_done_c;
  logic             replace_c;
  logic [ACC_W-1:0] cand_c;
  logic [ACC_W-1:0] best_d;
  logic [IDX_W-1:0] best_idx_d;

  assign accept_c    = (state_q == ST_ACCUM) && bus.s_valid;
  assign nth_beat_c  = (cnt_q == CNT_W'(ENS_N - 1));
  assign eof_c       = bus.s_last || nth_beat_c;
  assign scan_done_c = (scan_idx_q == IDX_W'(NUM_CLASSES - 1));

  // Per-class running sums with the incoming beat folded in.
  always_comb begin
    for (int c = 0; c < NUM_CLASSES; c++) begin
      acc_d[c] = acc_q[c] + ACC_W'(bus.s_data[c*SCORE_W +: SCORE_W]);
    end
  end

  // Index 0 seeds the running best; later classes replace it only when strictly larger.
  always_comb begin
    cand_c     = acc_q[scan_idx_q];
    replace_c  = (scan_idx_q == '0) || (cand_c > best_q);
    best_d     = replace_c ? cand_c : best_q;
    best_idx_d = replace_c ? scan_idx_q : best_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_ACCUM;
      for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= '0;
      cnt_q      <= '0;
      scan_idx_q <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
      m_valid_q  <= 1'b0;
      m_class_q  <= '0;
      m_score_q  <= '0;
      m_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept_c) begin
            for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= acc_d[c];
            cnt_q <= cnt_q + CNT_W'(1);
            if (eof_c) begin
              state_q    <= ST_SCAN;
              scan_idx_q <= '0;
              m_err_q    <= bus.s_last ^ nth_beat_c;
            end
          end
        end
        ST_SCAN: begin
          best_q     <= best_d;
          best_idx_q <= best_idx_d;
          scan_idx_q <= scan_idx_q + IDX_W'(1);
          if (scan_done_c) begin
            state_q   <= ST_OUT;
            m_valid_q <= 1'b1;
            m_class_q <= best_idx_d;
            m_score_q <= best_d;
          end
        end
        ST_OUT: begin
          // Clearing here keeps the clear and the next frame's first add on separate edges.
          if (bus.m_ready) begin
            state_q   <= ST_ACCUM;
            m_valid_q <= 1'b0;
            for (int c = 0; c < NUM_CLASSES; c++) acc_q[c] <= '0;
            cnt_q     <= '0;
          end
        end
        default: state_q <= ST_ACCUM;
      endcase
    end
  end

  assign bus.s_ready = (state_q == ST_ACCUM);
  assign bus.m_valid = m_valid_q;
  assign bus.m_class = m_class_q;
  assign bus.m_score = m_score_q;
  assign bus.m_err   = m_err_q;
endmodule

// File: tb/tb_ens_vote_argmax.sv
// Directed bench for ens_vote_argmax: table of frames with hand-computed winners, plus
// backpressure and reset-during-scan sequences.
module tb_ens_vote_argmax;
  localparam int unsigned NC = 10;
  localparam int unsigned SW = 2;
  localparam int unsigned EN = 4;
  localparam int unsigned IW = 4;
  localparam int unsigned DW = NC * SW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ens_vote_argmax_if #(.NUM_CLASSES(NC), .SCORE_W(SW), .ENS_N(EN), .IDX_W(IW)) bus ();

  ens_vote_argmax #(.NUM_CLASSES(NC), .SCORE_W(SW), .ENS_N(EN), .IDX_W(IW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    string                 name;
    logic [3:0][DW-1:0]    b;
    int                    nb;
    int                    last_at;
    int                    gap;
    int                    ecls;
    int                    escore;
    int                    eerr;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] fld(input int c, input int v);
    logic [DW-1:0] r;
    r = '0;
    r[c*SW +: SW] = SW'(v);
    return r;
  endfunction

  function automatic vec_t mkvec(input string name, input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                                 input logic [DW-1:0] b2, input logic [DW-1:0] b3, input int nb,
                                 input int last_at, input int gap, input int ecls, input int escore,
                                 input int eerr);
    vec_t v;
    v.name = name;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.nb = nb; v.last_at = last_at; v.gap = gap;
    v.ecls = ecls; v.escore = escore; v.eerr = eerr;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives each beat until accepted; returns #1 after the edge that accepted the last beat.
  task automatic send_frame(input vec_t v);
    int guard;
    for (int i = 0; i < v.nb; i++) begin
      if (i > 0) repeat (v.gap) tick();
      bus.s_valid = 1'b1;
      bus.s_data  = v.b[i];
      bus.s_last  = (i + 1 == v.last_at);
      guard = 0;
      while (!bus.s_ready && guard < 100) begin
        tick();
        guard++;
      end
      if (guard >= 100) chk($sformatf("%s.accept_timeout", v.name), 0, 1);
      tick();
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
    end
  endtask

  task automatic check_result(input vec_t v);
    int lat;
    lat = 0;
    while (!bus.m_valid && lat < 40) begin
      tick();
      lat++;
    end
    chk($sformatf("%s.latency", v.name), lat, NC);
    chk($sformatf("%s.m_class", v.name), int'(bus.m_class), v.ecls);
    chk($sformatf("%s.m_score", v.name), int'(bus.m_score), v.escore);
    chk($sformatf("%s.m_err", v.name), int'(bus.m_err), v.eerr);
    chk($sformatf("%s.s_ready_out", v.name), int'(bus.s_ready), 0);
  endtask

  task automatic handshake(input string name);
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    chk($sformatf("%s.m_valid_drop", name), int'(bus.m_valid), 0);
    chk($sformatf("%s.s_ready_back", name), int'(bus.s_ready), 1);
  endtask

  vec_t vecs[8];
  vec_t nominal;
  vec_t ones0;

  initial begin
    logic [DW-1:0] z;
    z = '0;
    nominal = mkvec("nominal", fld(7,3), fld(7,3), fld(7,3), fld(7,3), 4, 4, 0, 7, 12, 0);
    ones0   = mkvec("after_bp", fld(0,1), fld(0,1), fld(0,1), fld(0,1), 4, 4, 0, 0, 4, 0);
    vecs[0] = nominal;
    vecs[1] = mkvec("tie", fld(2,3) | fld(5,3), fld(2,3) | fld(5,3), fld(1,2) | fld(9,2),
                    fld(1,2) | fld(9,2), 4, 4, 0, 2, 6, 0);
    vecs[2] = mkvec("short", fld(3,2), fld(3,2), z, z, 2, 2, 0, 3, 4, 1);
    vecs[3] = mkvec("bubbles", fld(7,3), fld(7,3), fld(7,3), fld(7,3), 4, 4, 3, 7, 12, 0);
    vecs[4] = mkvec("no_last", fld(9,1), fld(9,1), fld(9,1), fld(9,1), 4, 0, 0, 9, 4, 1);
    vecs[5] = mkvec("zeros", z, z, z, z, 4, 4, 0, 0, 0, 0);
    vecs[6] = mkvec("top_class", fld(9,3) | fld(8,2), fld(9,3) | fld(8,2), fld(9,3) | fld(8,2),
                    fld(9,3) | fld(8,2), 4, 4, 0, 9, 12, 0);
    vecs[7] = mkvec("one_beat", fld(4,3) | fld(6,2), z, z, z, 1, 1, 1, 4, 3, 1);

    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.s_last  = 1'b0;
    bus.m_ready = 1'b0;
    repeat (2) tick();
    chk("rst.s_ready", int'(bus.s_ready), 1);
    chk("rst.m_valid", int'(bus.m_valid), 0);
    chk("rst.m_class", int'(bus.m_class), 0);
    chk("rst.m_score", int'(bus.m_score), 0);
    chk("rst.m_err", int'(bus.m_err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    foreach (vecs[k]) begin
      send_frame(vecs[k]);
      check_result(vecs[k]);
      handshake(vecs[k].name);
    end

    // Backpressure: result must hold while input is offered and refused.
    send_frame(nominal);
    check_result(nominal);
    bus.s_valid = 1'b1;
    bus.s_data  = fld(0,3);
    bus.s_last  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp%0d.m_valid", k), int'(bus.m_valid), 1);
      chk($sformatf("bp%0d.m_class", k), int'(bus.m_class), 7);
      chk($sformatf("bp%0d.m_score", k), int'(bus.m_score), 12);
      chk($sformatf("bp%0d.s_ready", k), int'(bus.s_ready), 0);
    end
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    handshake("bp");
    send_frame(ones0);
    check_result(ones0);
    handshake("after_bp");

    // Reset during the scan discards the frame with no stale result.
    send_frame(nominal);
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_scan.m_valid", int'(bus.m_valid), 0);
    chk("rst_scan.s_ready", int'(bus.s_ready), 1);
    chk("rst_scan.m_score", int'(bus.m_score), 0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 15; k++) begin
        tick();
        if (bus.m_valid) seen++;
      end
      chk("rst_scan.no_stale", seen, 0);
    end
    send_frame(nominal);
    check_result(nominal);
    handshake("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
